// File: rtl/glyph_frame_source.sv
// glyph_frame_source: run-time writable ROWS x COLS bitmap source for the LCD
// monitor row bus. Writes land in a shadow buffer and are copied to the active
// buffer only at a frame boundary. Animation modes: static, scroll left,
// scroll right and blink. The row bus is registered (one cycle behind state).
module glyph_frame_source #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int TICK_DIV = 6000000
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    wr_en,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] wr_row,
    input  logic [COLS-1:0]                         wr_data,
    input  logic                                    commit,
    input  logic                                    frame_done,
    input  logic [1:0]                              mode,
    input  logic [3:0]                              speed,
    output logic [ROWS*COLS-1:0]                    rows_out,
    output logic                                    commit_pending,
    output logic                                    step_pulse
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OW = $clog2(COLS);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    // Bitmap storage: staging copy and the copy actually shown
    logic [COLS-1:0] shadow_reg [ROWS];
    logic [COLS-1:0] active_reg [ROWS];
    logic [COLS-1:0] view_reg   [ROWS];

    // Animation and commit state
    logic [PW-1:0] presc_reg;
    logic [3:0]    step_cnt_reg;
    logic [OW-1:0] offset_reg;
    logic [OW-1:0] offset_next;
    logic          phase_reg;
    logic          phase_next;
    logic [1:0]    prev_mode_reg;
    logic          pending_reg;
    logic          step_pulse_reg;

    logic tick;
    logic step;
    logic copy;
    logic wr_row_ok;

    assign tick      = (presc_reg == PW'(TICK_DIV - 1));
    assign step      = tick && (step_cnt_reg >= speed);
    // A commit arriving together with frame_done is served immediately
    assign copy      = frame_done && (pending_reg || commit);
    assign wr_row_ok = ({1'b0, wr_row} < (RW + 1)'(ROWS));

    assign commit_pending = pending_reg;
    assign step_pulse     = step_pulse_reg;

    // Offset and blink phase: a mode change forces both to zero and wins over a step
    always_comb begin
        offset_next = offset_reg;
        phase_next  = phase_reg;
        if (mode != prev_mode_reg) begin
            offset_next = '0;
            phase_next  = 1'b0;
        end else if (step) begin
            case (mode)
                MODE_LEFT:  offset_next = (offset_reg == OW'(COLS - 1)) ? '0 : offset_reg + OW'(1);
                MODE_RIGHT: offset_next = (offset_reg == '0) ? OW'(COLS - 1) : offset_reg - OW'(1);
                MODE_BLINK: phase_next  = ~phase_reg;
                default:    ;
            endcase
        end
    end

    // Prescaler, step counter, commit flag and animation registers
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg      <= '0;
            step_cnt_reg   <= '0;
            offset_reg     <= '0;
            phase_reg      <= 1'b0;
            prev_mode_reg  <= MODE_STATIC;
            pending_reg    <= 1'b0;
            step_pulse_reg <= 1'b0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
                // >= keeps a mid-count speed reduction from running past the limit
                step_cnt_reg <= step ? '0 : step_cnt_reg + 4'd1;
            end
            step_pulse_reg <= step;
            offset_reg     <= offset_next;
            phase_reg      <= phase_next;
            prev_mode_reg  <= mode;
            if (copy) begin
                pending_reg <= 1'b0;
            end else if (commit) begin
                pending_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] rotated;
            logic [COLS-1:0] view_next;

            // Shadow row write; out-of-range row indices are dropped
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg[gi] <= '0;
                end else if (wr_en && wr_row_ok && (wr_row == RW'(gi))) begin
                    shadow_reg[gi] <= wr_data;
                end
            end

            // Frame-boundary copy reads the shadow value from before any same-cycle write
            always_ff @(posedge clk) begin
                if (reset) begin
                    active_reg[gi] <= '0;
                end else if (copy) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
            end

            // Rotate the active row: pixel i shows pixel (i + offset) mod COLS
            always_comb begin
                rotated = '0;
                for (int i = 0; i < COLS; i++) begin
                    rotated[i] = active_reg[gi][((i + int'(offset_reg)) >= COLS) ?
                                                (i + int'(offset_reg) - COLS) :
                                                (i + int'(offset_reg))];
                end
                if (prev_mode_reg == MODE_BLINK) begin
                    view_next = phase_reg ? '0 : active_reg[gi];
                end else begin
                    view_next = rotated;
                end
            end

            // Registered row output, one cycle behind the state it shows
            always_ff @(posedge clk) begin
                if (reset) begin
                    view_reg[gi] <= '0;
                end else begin
                    view_reg[gi] <= view_next;
                end
            end

            assign rows_out[gi*COLS +: COLS] = view_reg[gi];
        end
    endgenerate

endmodule
